vga_sync_multimode: RTL and testbench
=====================================

VGA_SYNC_MULTIMODE -- requirements
Module: vga_sync_multimode

Interface
REQ-001 Parameter DEFAULT_MODE, default 0, timing mode loaded at reset (must be 0..6).
REQ-002 Parameter CNT_W, default 12, width of internal counters and address outputs (must be >= 12).
REQ-003 vga_clk  in  1  pixel clock, the only clock; all logic on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 mode_sel  in  3  requested timing mode code, sampled only when mode_req=1.
REQ-006 mode_req  in  1  single-cycle mode-change request strobe.
REQ-007 HSYNC_Sig  out  1  horizontal sync, polarity per mode table.
REQ-008 VSYNC_Sig  out  1  vertical sync, polarity per mode table.
REQ-009 Ready_Sig  out  1  high during the active display region.
REQ-010 Column_Addr_Sig  out  CNT_W  active-region pixel x; 0 outside the active region.
REQ-011 Row_Addr_Sig  out  CNT_W  active-region line y; 0 outside the active region.
REQ-012 frame_start  out  1  one-cycle pulse at counter position h=0,v=0.
REQ-013 mode_cur  out  3  mode currently being generated.
REQ-014 mode_busy  out  1  high while a mode change is pending.

Function
REQ-015 Mode table (H sync/bp/active/fp; V sync/bp/active/fp; Hpol,Vpol; P=active-high, N=active-low) SHALL be:
- 0: 640x480@60: 96/48/640/16; 2/33/480/10; N,N
- 1: 640x480@75: 64/120/640/16; 3/16/480/1; N,N
- 2: 800x600@60: 128/88/800/40; 4/23/600/1; P,P
- 3: 800x600@75: 80/160/800/16; 3/21/600/1; P,P
- 4: 1024x768@60: 136/160/1024/24; 6/29/768/3; N,N
- 5: 1440x900@60: 152/232/1440/80; 6/25/900/3; N,P
- 6: 1920x1080@60: 44/148/1920/88; 5/36/1080/4; P,P
REQ-016 Code 7 SHALL be invalid; a request with mode_sel=7 is ignored entirely.
REQ-017 h counter SHALL count 0..HT-1 (HT = sum of the H fields) and wrap to 0; v SHALL increment on each h wrap, counting 0..VT-1, then wrap to 0.
REQ-018 Position 0 of each counter SHALL be the first cycle of its sync pulse; order is sync, back porch, active, front porch.
REQ-019 Sync SHALL be active for h<HS (resp. v<VS), driven at the mode polarity, else at the inactive level.
REQ-020 Ready_Sig SHALL be 1 iff HS+HBP <= h < HS+HBP+HA and VS+VBP <= v < VS+VBP+VA.
REQ-021 When Ready_Sig=1, Column_Addr_Sig SHALL be h-(HS+HBP) and Row_Addr_Sig SHALL be v-(VS+VBP); both are 0 otherwise.
REQ-022 All outputs SHALL be registered and mutually aligned, with exactly one vga_clk of latency from the counter position they decode.
REQ-023 On a valid mode_req with mode_sel != mode_cur, the block SHALL latch mode_sel as pending and set mode_busy=1 on the next cycle.
REQ-024 A later valid request while a change is pending SHALL overwrite the pending code; a request equal to mode_cur SHALL cancel the pending change (mode_busy=0).
REQ-025 The pending mode SHALL be applied on the last cycle of a frame (h=HT-1, v=VT-1): counters wrap to 0, mode_cur updates and mode_busy clears, so the next frame is generated entirely in the new mode; there SHALL be no mid-frame switch.
REQ-026 A request arriving on the frame-end cycle itself SHALL become pending and apply at the following frame end; the value pending before that cycle is applied.
REQ-027 With no change pending, mode_cur and all timing SHALL be unchanged across frames.

Reset
REQ-028 While rst=1: counters=0, mode_cur=DEFAULT_MODE, pending cleared, mode_busy=0, Ready_Sig=0, addresses=0, frame_start=0, and syncs at the inactive level of DEFAULT_MODE.
REQ-029 On the first vga_clk edge after rst falls, frame_start=1 and both syncs are active (decode of h=0,v=0).
REQ-030 Reset asserted mid-frame or mid-request SHALL immediately discard any pending mode change.

Verification
REQ-031 Mode 0: release reset -> frame_start period 420000 cycles; HSYNC low 96 of every 800 cycles; VSYNC low for 1600 cycles per frame.
REQ-032 Mode 0: Ready_Sig first rises at h=144,v=35 with column=0,row=0; last active pixel is column=639,row=479; 307200 Ready cycles per frame.
REQ-033 Mode 0, mode_req with mode_sel=6 mid-frame -> mode_busy=1 until frame end; the next frame is 2200x1125 with HSYNC high for 44 cycles; mode_cur=6.
REQ-034 Request 2, then request 4 before frame end -> mode 4 applied (period 1344x806); request 2 then request 0 (current mode) -> no change, mode_busy=0.
REQ-035 mode_sel=7 strobe -> no change in mode_busy or timing; mode_req on the frame-end cycle -> applied one frame later.
REQ-036 Assert rst mid-frame with a change pending -> outputs at reset values immediately; after release, DEFAULT_MODE timing is generated and mode_busy=0.

Source files
------------

// File: rtl/vga_sync_multimode_if.sv
// Mode-request and video-timing bundle for vga_sync_multimode.
//   mode_sel/mode_req : mode-change request (driven by the controller)
//   HSYNC_Sig/VSYNC_Sig, Ready_Sig, Column_Addr_Sig/Row_Addr_Sig,
//   frame_start, mode_cur, mode_busy : registered timing outputs
// master = controller / consumer side, slave = the sync generator.
interface vga_sync_multimode_if #(
  parameter int unsigned CNT_W = 12
);
  logic [2:0]       mode_sel;
  logic             mode_req;
  logic             HSYNC_Sig;
  logic             VSYNC_Sig;
  logic             Ready_Sig;
  logic [CNT_W-1:0] Column_Addr_Sig;
  logic [CNT_W-1:0] Row_Addr_Sig;
  logic             frame_start;
  logic [2:0]       mode_cur;
  logic             mode_busy;

  modport master (
    output mode_sel, mode_req,
    input  HSYNC_Sig, VSYNC_Sig, Ready_Sig, Column_Addr_Sig, Row_Addr_Sig,
    input  frame_start, mode_cur, mode_busy
  );

  modport slave (
    input  mode_sel, mode_req,
    output HSYNC_Sig, VSYNC_Sig, Ready_Sig, Column_Addr_Sig, Row_Addr_Sig,
    output frame_start, mode_cur, mode_busy
  );
endinterface

// File: rtl/vga_sync_multimode.sv
// Multi-mode VGA sync generator (7 fixed timing modes).
// Counters run sync -> back porch -> active -> front porch, position 0 being
// the first sync cycle. All outputs are registered decodes of the counter
// position (one vga_clk of latency). Mode changes are queued and applied only
// on the last cycle of a frame, so every frame is generated in a single mode.
//   vga_clk : pixel clock
//   rst     : asynchronous active-high reset
//   bus     : vga_sync_multimode_if.slave (requests in, timing outputs out)
module vga_sync_multimode #(
  parameter int unsigned DEFAULT_MODE = 0,
  parameter int unsigned CNT_W        = 12
) (
  input logic                 vga_clk,
  input logic                 rst,
  vga_sync_multimode_if.slave bus
);

  typedef struct packed {
    logic [CNT_W-1:0] hs;
    logic [CNT_W-1:0] hbp;
    logic [CNT_W-1:0] ha;
    logic [CNT_W-1:0] hfp;
    logic [CNT_W-1:0] vs;
    logic [CNT_W-1:0] vbp;
    logic [CNT_W-1:0] va;
    logic [CNT_W-1:0] vfp;
    logic             hpol;  // 1 = active-high sync
    logic             vpol;
  } timing_t;

  function automatic timing_t mk(input int unsigned hs, hbp, ha, hfp, vs, vbp, va, vfp,
                                 input logic hp, vp);
    timing_t t;
    t.hs   = CNT_W'(hs);
    t.hbp  = CNT_W'(hbp);
    t.ha   = CNT_W'(ha);
    t.hfp  = CNT_W'(hfp);
    t.vs   = CNT_W'(vs);
    t.vbp  = CNT_W'(vbp);
    t.va   = CNT_W'(va);
    t.vfp  = CNT_W'(vfp);
    t.hpol = hp;
    t.vpol = vp;
    return t;
  endfunction

  function automatic timing_t mode_timing(input logic [2:0] m);
    timing_t t;
    case (m)
      3'd1:    t = mk(64,  120, 640,  16, 3, 16, 480,  1, 1'b0, 1'b0);
      3'd2:    t = mk(128, 88,  800,  40, 4, 23, 600,  1, 1'b1, 1'b1);
      3'd3:    t = mk(80,  160, 800,  16, 3, 21, 600,  1, 1'b1, 1'b1);
      3'd4:    t = mk(136, 160, 1024, 24, 6, 29, 768,  3, 1'b0, 1'b0);
      3'd5:    t = mk(152, 232, 1440, 80, 6, 25, 900,  3, 1'b0, 1'b1);
      3'd6:    t = mk(44,  148, 1920, 88, 5, 36, 1080, 4, 1'b1, 1'b1);
      // Code 7 never reaches mode_cur_q; treat it like mode 0.
      default: t = mk(96,  48,  640,  16, 2, 33, 480, 10, 1'b0, 1'b0);
    endcase
    return t;
  endfunction

  localparam timing_t RstTiming = mode_timing(3'(DEFAULT_MODE));

  // State
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [2:0]       mode_cur_q, mode_d;
  logic [2:0]       pend_mode_q, pend_mode_d;
  logic             pend_valid_q, pend_valid_d;

  // Registered outputs
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             ready_q, ready_d, fs_q, fs_d;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;

  // Decoded timing of the current mode
  timing_t          tm;
  logic [CNT_W-1:0] h_act_lo, h_act_hi, h_tot;
  logic [CNT_W-1:0] v_act_lo, v_act_hi, v_tot;
  logic             h_last, v_last, frame_end, req_valid;

  always_comb begin
    tm        = mode_timing(mode_cur_q);
    h_act_lo  = tm.hs + tm.hbp;
    h_act_hi  = h_act_lo + tm.ha;
    h_tot     = h_act_hi + tm.hfp;
    v_act_lo  = tm.vs + tm.vbp;
    v_act_hi  = v_act_lo + tm.va;
    v_tot     = v_act_hi + tm.vfp;
    h_last    = (h_q == h_tot - CNT_W'(1));
    v_last    = (v_q == v_tot - CNT_W'(1));
    frame_end = h_last && v_last;
  end

  // Position counters
  always_comb begin
    h_d = h_last ? '0 : h_q + CNT_W'(1);
    v_d = v_q;
    if (h_last) begin
      v_d = v_last ? '0 : v_q + CNT_W'(1);
    end
  end

  // Mode-change queue. The frame-end switch is resolved first so that a
  // request landing on the frame-end cycle is compared against the mode
  // about to start and stays pending for the next frame end.
  always_comb begin
    req_valid    = bus.mode_req && (bus.mode_sel != 3'd7);
    mode_d       = mode_cur_q;
    pend_mode_d  = pend_mode_q;
    pend_valid_d = pend_valid_q;
    if (frame_end) begin
      if (pend_valid_q) begin
        mode_d = pend_mode_q;
      end
      pend_valid_d = 1'b0;
    end
    if (req_valid) begin
      if (bus.mode_sel != mode_d) begin
        pend_valid_d = 1'b1;
        pend_mode_d  = bus.mode_sel;
      end else begin
        pend_valid_d = 1'b0;
      end
    end
  end

  // Output decode of the present counter position (registered below)
  always_comb begin
    hsync_d = (h_q < tm.hs) ? tm.hpol : ~tm.hpol;
    vsync_d = (v_q < tm.vs) ? tm.vpol : ~tm.vpol;
    ready_d = (h_q >= h_act_lo) && (h_q < h_act_hi) && (v_q >= v_act_lo) && (v_q < v_act_hi);
    col_d   = ready_d ? h_q - h_act_lo : '0;
    row_d   = ready_d ? v_q - v_act_lo : '0;
    fs_d    = (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      h_q          <= '0;
      v_q          <= '0;
      mode_cur_q   <= 3'(DEFAULT_MODE);
      pend_mode_q  <= '0;
      pend_valid_q <= 1'b0;
      hsync_q      <= ~RstTiming.hpol;
      vsync_q      <= ~RstTiming.vpol;
      ready_q      <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      fs_q         <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      mode_cur_q   <= mode_d;
      pend_mode_q  <= pend_mode_d;
      pend_valid_q <= pend_valid_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      ready_q      <= ready_d;
      col_q        <= col_d;
      row_q        <= row_d;
      fs_q         <= fs_d;
    end
  end

  assign bus.HSYNC_Sig       = hsync_q;
  assign bus.VSYNC_Sig       = vsync_q;
  assign bus.Ready_Sig       = ready_q;
  assign bus.Column_Addr_Sig = col_q;
  assign bus.Row_Addr_Sig    = row_q;
  assign bus.frame_start     = fs_q;
  assign bus.mode_cur        = mode_cur_q;
  assign bus.mode_busy       = pend_valid_q;

endmodule

// File: tb/tb_vga_sync_multimode.sv
// Directed bench for vga_sync_multimode. Full frames are hundreds of
// thousands of cycles, so the bench fast-forwards the position counters
// (force/release with no clock edge in between) to just before the points
// of interest, then lets the design run freely across them.
module tb_vga_sync_multimode;

  logic vga_clk;
  logic rst;

  vga_sync_multimode_if #(.CNT_W(12)) bus ();

  vga_sync_multimode #(
    .DEFAULT_MODE(0),
    .CNT_W       (12)
  ) dut (
    .vga_clk(vga_clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] jump_h, jump_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge vga_clk);
  endtask

  // Place the counters at (h,v); the next sample shows the decode of (h,v).
  task automatic jump(input logic [11:0] h, input logic [11:0] v);
    @(negedge vga_clk);
    jump_h = h;
    jump_v = v;
    force dut.h_q = jump_h;
    force dut.v_q = jump_v;
    #1;
    release dut.h_q;
    release dut.v_q;
  endtask

  // Six samples from a jump to 5 positions before frame end; returns the
  // frame_start pattern (bit k = sample k).
  task automatic run_to_frame(input logic [11:0] h, input logic [11:0] v,
                              output logic [5:0] fs_vec);
    jump(h, v);
    fs_vec = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      fs_vec[k] = bus.frame_start;
    end
  endtask

  task automatic request(input logic [2:0] sel);
    bus.mode_sel = sel;
    bus.mode_req = 1'b1;
    tick();
    bus.mode_req = 1'b0;
  endtask

  int         fs_cnt, hs_cnt, vs_low, ready_cnt, first_ready, col0, row0, last_col;
  logic [5:0] fsv;
  logic [2:0] rdy_vec;

  initial begin
    rst          = 1'b1;
    bus.mode_sel = 3'd0;
    bus.mode_req = 1'b0;
    repeat (3) tick();

    // Reset values (mode 0 syncs are active-low, so idle high)
    chk("rst_hsync", bus.HSYNC_Sig, 1);
    chk("rst_vsync", bus.VSYNC_Sig, 1);
    chk("rst_ready", bus.Ready_Sig, 0);
    chk("rst_col", bus.Column_Addr_Sig, 0);
    chk("rst_row", bus.Row_Addr_Sig, 0);
    chk("rst_fs", bus.frame_start, 0);
    chk("rst_mode", bus.mode_cur, 0);
    chk("rst_busy", bus.mode_busy, 0);

    // Mode 0 from reset: sample p shows the decode of position p.
    rst         = 1'b0;
    fs_cnt      = 0;
    hs_cnt      = 0;
    vs_low      = 0;
    ready_cnt   = 0;
    first_ready = -1;
    col0        = -1;
    row0        = -1;
    last_col    = -1;
    for (int p = 0; p < 28800; p++) begin
      tick();
      if (p == 0) begin
        chk("first_fs", bus.frame_start, 1);
        chk("first_hsync", bus.HSYNC_Sig, 0);
        chk("first_vsync", bus.VSYNC_Sig, 0);
      end
      if (bus.frame_start) fs_cnt++;
      if (p < 800 && !bus.HSYNC_Sig) hs_cnt++;
      if (!bus.VSYNC_Sig) vs_low++;
      if (bus.Ready_Sig) begin
        ready_cnt++;
        if (first_ready < 0) begin
          first_ready = p;
          col0        = int'(bus.Column_Addr_Sig);
          row0        = int'(bus.Row_Addr_Sig);
        end
      end
      if (p == 28783) last_col = int'(bus.Column_Addr_Sig);
    end
    chk("m0_fs_count", fs_cnt, 1);
    chk("m0_hsync_low", hs_cnt, 96);
    chk("m0_vsync_low", vs_low, 1600);
    chk("m0_first_ready", first_ready, 28144);  // 35*800 + 144
    chk("m0_first_col", col0, 0);
    chk("m0_first_row", row0, 0);
    chk("m0_ready_line", ready_cnt, 640);
    chk("m0_line_last_col", last_col, 639);

    // Last active pixel of the frame: h=783, v=514
    jump(12'd782, 12'd514);
    tick();
    chk("m0_px638_col", bus.Column_Addr_Sig, 638);
    chk("m0_px638_row", bus.Row_Addr_Sig, 479);
    tick();
    chk("m0_last_ready", bus.Ready_Sig, 1);
    chk("m0_last_col", bus.Column_Addr_Sig, 639);
    chk("m0_last_row", bus.Row_Addr_Sig, 479);
    tick();
    chk("m0_fp_ready", bus.Ready_Sig, 0);
    chk("m0_fp_col", bus.Column_Addr_Sig, 0);

    // Frame wrap with nothing pending
    run_to_frame(12'd795, 12'd524, fsv);
    chk("m0_wrap_fs", fsv, 6'b100000);
    chk("m0_wrap_mode", bus.mode_cur, 0);

    // Change to mode 6 mid-frame
    request(3'd6);
    chk("req6_busy", bus.mode_busy, 1);
    chk("req6_mode_hold", bus.mode_cur, 0);
    jump(12'd795, 12'd524);
    repeat (4) tick();  // decode of h=798
    chk("req6_busy_late", bus.mode_busy, 1);
    chk("req6_mode_late", bus.mode_cur, 0);
    tick();
    tick();             // decode of (0,0) in mode 6
    chk("m6_fs", bus.frame_start, 1);
    chk("m6_mode", bus.mode_cur, 6);
    chk("m6_busy", bus.mode_busy, 0);
    chk("m6_vsync", bus.VSYNC_Sig, 1);
    hs_cnt = bus.HSYNC_Sig ? 1 : 0;
    for (int p = 1; p < 2200; p++) begin
      tick();
      if (bus.HSYNC_Sig) hs_cnt++;
    end
    chk("m6_hsync_high", hs_cnt, 44);
    tick();             // h=0, v=1
    chk("m6_line2_hsync", bus.HSYNC_Sig, 1);
    chk("m6_line2_fs", bus.frame_start, 0);
    jump(12'd190, 12'd41);
    for (int k = 0; k < 3; k++) begin
      tick();
      rdy_vec[k] = bus.Ready_Sig;
    end
    chk("m6_ready_edge", rdy_vec, 3'b100);
    chk("m6_ready_col", bus.Column_Addr_Sig, 0);
    chk("m6_ready_row", bus.Row_Addr_Sig, 0);

    // Pending 2 overwritten by 4
    request(3'd2);
    request(3'd4);
    chk("req24_busy", bus.mode_busy, 1);
    run_to_frame(12'd2195, 12'd1124, fsv);
    chk("m4_wrap_fs", fsv, 6'b100000);
    chk("m4_mode", bus.mode_cur, 4);
    chk("m4_busy", bus.mode_busy, 0);
    hs_cnt = bus.HSYNC_Sig ? 0 : 1;
    for (int p = 1; p < 1344; p++) begin
      tick();
      if (!bus.HSYNC_Sig) hs_cnt++;
    end
    chk("m4_hsync_low", hs_cnt, 136);
    run_to_frame(12'd1339, 12'd805, fsv);
    chk("m4_frame_len", fsv, 6'b100000);

    // Request then cancel with the current mode; code 7 ignored
    request(3'd2);
    chk("cancel_busy_set", bus.mode_busy, 1);
    request(3'd4);
    chk("cancel_busy_clr", bus.mode_busy, 0);
    request(3'd7);
    chk("code7_busy", bus.mode_busy, 0);
    run_to_frame(12'd1339, 12'd805, fsv);
    chk("cancel_mode", bus.mode_cur, 4);

    // Request landing on the frame-end cycle waits one more frame
    jump(12'd1339, 12'd805);
    repeat (4) tick();  // counter now sits at (1343,805)
    request(3'd1);
    chk("fe_req_mode", bus.mode_cur, 4);
    chk("fe_req_busy", bus.mode_busy, 1);
    tick();
    chk("fe_req_fs", bus.frame_start, 1);
    chk("fe_req_mode_next", bus.mode_cur, 4);
    run_to_frame(12'd1339, 12'd805, fsv);
    chk("m1_wrap_fs", fsv, 6'b100000);
    chk("m1_mode", bus.mode_cur, 1);
    chk("m1_busy", bus.mode_busy, 0);
    hs_cnt = bus.HSYNC_Sig ? 0 : 1;
    for (int p = 1; p < 840; p++) begin
      tick();
      if (!bus.HSYNC_Sig) hs_cnt++;
    end
    chk("m1_hsync_low", hs_cnt, 64);

    // Reset mid-frame with a change pending
    request(3'd3);
    chk("rst_pend_busy", bus.mode_busy, 1);
    jump(12'd400, 12'd200);
    repeat (2) tick();
    chk("pre_rst_ready", bus.Ready_Sig, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", bus.mode_busy, 0);
    chk("async_rst_mode", bus.mode_cur, 0);
    chk("async_rst_ready", bus.Ready_Sig, 0);
    chk("async_rst_col", bus.Column_Addr_Sig, 0);
    chk("async_rst_hsync", bus.HSYNC_Sig, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_fs", bus.frame_start, 1);
    chk("post_rst_mode", bus.mode_cur, 0);
    chk("post_rst_busy", bus.mode_busy, 0);
    hs_cnt = bus.HSYNC_Sig ? 0 : 1;
    for (int p = 1; p < 800; p++) begin
      tick();
      if (!bus.HSYNC_Sig) hs_cnt++;
    end
    chk("post_rst_hsync_low", hs_cnt, 96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
